// File: rtl/pc_sequencer_pkg.sv
// Shared sequencer types: FSM state encoding and the default sequential PC step.
package SequencerPackage;

    typedef enum logic [1:0] {
        SEQ_FETCH   = 2'd0,
        SEQ_EXECUTE = 2'd1,
        SEQ_HALT    = 2'd2
    } SequencerState;

    localparam logic [31:0] DEFAULT_PC_STEP = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of instruction-memory, branch-unit and execute-stage signals seen by the sequencer.
interface pc_sequencer_if;

    logic        imemRequest;
    logic [31:0] fetchAddress;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] instruction;
    logic        instructionValid;
    logic [31:0] pcAddress;
    logic        execDone;
    logic        stall;
    logic        shouldUseNewPC;
    logic [31:0] branchTo;
    logic        halt;
    logic        flush;
    logic        alignmentFault;
    logic [31:0] retiredCount;

    modport master (
        output imemRequest, fetchAddress, instruction, instructionValid, pcAddress,
               flush, alignmentFault, retiredCount,
        input  imemReady, imemData, execDone, stall, shouldUseNewPC, branchTo, halt
    );

    modport slave (
        input  imemRequest, fetchAddress, instruction, instructionValid, pcAddress,
               flush, alignmentFault, retiredCount,
        output imemReady, imemData, execDone, stall, shouldUseNewPC, branchTo, halt
    );

endinterface

// File: rtl/pc_sequencer.sv
// Program-counter owner: fetches one instruction, holds it through execute, then
// advances or redirects the PC on retire. A halt at retire parks the core until reset.
module pc_sequencer
    import SequencerPackage::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.master bus
);

    SequencerState state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   count_q, count_d;
    logic          flush_q, flush_d;
    logic          fault_q, fault_d;
    logic          retire;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        flush_d = 1'b0;
        fault_d = fault_q;
        retire  = (state_q == SEQ_EXECUTE) && bus.execDone && !bus.stall;

        case (state_q)
            SEQ_FETCH: begin
                if (bus.imemReady) begin
                    instr_d = bus.imemData;
                    state_d = SEQ_EXECUTE;
                end
            end
            SEQ_EXECUTE: begin
                if (retire) begin
                    // Redirect targets are forced word-aligned; a misaligned request is recorded.
                    if (bus.shouldUseNewPC) begin
                        pc_d    = {bus.branchTo[31:2], 2'b00};
                        flush_d = 1'b1;
                        fault_d = fault_q | (bus.branchTo[1:0] != 2'b00);
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                    count_d = count_q + 32'd1;
                    state_d = bus.halt ? SEQ_HALT : SEQ_FETCH;
                end
            end
            default: state_d = SEQ_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEQ_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            count_q <= 32'd0;
            flush_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
            flush_q <= flush_d;
            fault_q <= fault_d;
        end
    end

    // The request is gated by reset so it drops the moment reset asserts, not at the next edge.
    assign bus.imemRequest      = rst && (state_q == SEQ_FETCH);
    assign bus.fetchAddress     = pc_q;
    assign bus.instructionValid = (state_q == SEQ_EXECUTE);
    assign bus.instruction      = instr_q;
    assign bus.pcAddress        = pc_q;
    assign bus.flush            = flush_q;
    assign bus.alignmentFault   = fault_q;
    assign bus.retiredCount     = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer plus directed reset, wrap and halt checks.
module tb_pc_sequencer;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] count;
    } IssueRec;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] count;
        logic        flush;
        logic        fault;
        logic        halted;
    } RetireRec;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if bus ();
    pc_sequencer_if bus2 ();

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));
    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (.clk(clk), .rst(rst), .bus(bus2));

    int checks = 0;
    int fails  = 0;

    IssueRec  issueQ[$];
    RetireRec retireQ[$];

    logic [31:0] mPc    = 32'd0;
    logic [31:0] mCount = 32'd0;
    logic        mFault = 1'b0;
    bit          monitorOn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full instruction: fetch with random latency, random non-retiring execute cycles, then retire.
    task automatic applyStimulus(input int n, input bit lastHalt);
        int          waits;
        int          holds;
        logic [31:0] data;
        logic [31:0] target;
        bit          taken;
        RetireRec    rr;

        waits = $urandom_range(0, 2);
        for (int i = 0; i < waits; i++) begin
            bus.imemReady = 1'b0;
            bus.stall     = 1'($urandom % 2);
            bus.execDone  = 1'($urandom % 2);
            tick();
        end
        data          = $urandom;
        bus.imemReady = 1'b1;
        bus.imemData  = data;
        issueQ.push_back('{instr: data, pc: mPc, count: mCount});
        tick();
        bus.imemReady = 1'b0;

        holds = $urandom_range(0, 3);
        for (int i = 0; i < holds; i++) begin
            bus.execDone       = 1'($urandom % 2);
            bus.stall          = bus.execDone ? 1'b1 : 1'($urandom % 2);
            bus.imemReady      = 1'($urandom % 2);
            bus.imemData       = $urandom;
            bus.shouldUseNewPC = 1'($urandom % 2);
            bus.branchTo       = $urandom;
            bus.halt           = 1'($urandom % 2);
            tick();
        end

        taken = 1'($urandom % 2);
        case ($urandom % 4)
            0:       target = $urandom & 32'hFFFF_FFFC;
            1:       target = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            2:       target = 32'hFFFF_FFFC;
            default: target = $urandom;
        endcase
        if (n < 60) target = target & 32'hFFFF_FFFC;

        bus.imemReady      = 1'($urandom % 2);
        bus.execDone       = 1'b1;
        bus.stall          = 1'b0;
        bus.shouldUseNewPC = taken;
        bus.branchTo       = target;
        bus.halt           = lastHalt;

        if (taken) begin
            mFault = mFault | ((target % 4) != 0);
            mPc    = target - (target % 4);
        end else begin
            mPc = mPc + 32'd4;
        end
        mCount = mCount + 32'd1;
        rr.pc = mPc; rr.count = mCount; rr.flush = taken; rr.fault = mFault; rr.halted = lastHalt;
        retireQ.push_back(rr);
        tick();

        bus.execDone       = 1'b0;
        bus.stall          = 1'b0;
        bus.halt           = 1'b0;
        bus.imemReady      = 1'b0;
        bus.shouldUseNewPC = 1'b0;
    endtask

    // Monitor: pops an issue record when an instruction starts executing, a retire record when it ends.
    initial begin
        IssueRec     ir;
        RetireRec    rr;
        bit          prevValid;
        logic [31:0] curPc;
        logic [31:0] curCount;
        prevValid = 1'b0;
        curPc     = 32'd0;
        curCount  = 32'd0;
        forever begin
            @(negedge clk);
            if (monitorOn) begin
                if (bus.instructionValid && !prevValid) begin
                    if (issueQ.size() == 0) begin
                        checks++; fails++;
                        $display("[TB] FAIL issue_unexpected: got instructionValid 1 expected no pending fetch");
                    end else begin
                        ir = issueQ.pop_front();
                        checkOutput("issue_instruction", bus.instruction, ir.instr);
                        curPc    = ir.pc;
                        curCount = ir.count;
                    end
                end
                if (bus.instructionValid) begin
                    checkOutput("exec_pc_hold", bus.pcAddress, curPc);
                    checkOutput("exec_count_hold", bus.retiredCount, curCount);
                    checkOutput("exec_flush_low", 32'(bus.flush), 32'd0);
                    checkOutput("exec_no_request", 32'(bus.imemRequest), 32'd0);
                end
                if (!bus.instructionValid && prevValid) begin
                    if (retireQ.size() == 0) begin
                        checks++; fails++;
                        $display("[TB] FAIL retire_unexpected: got retire expected none pending");
                    end else begin
                        rr = retireQ.pop_front();
                        checkOutput("retire_pc", bus.pcAddress, rr.pc);
                        checkOutput("retire_fetch_addr", bus.fetchAddress, rr.pc);
                        checkOutput("retire_count", bus.retiredCount, rr.count);
                        checkOutput("retire_flush", 32'(bus.flush), 32'(rr.flush));
                        checkOutput("retire_fault", 32'(bus.alignmentFault), 32'(rr.fault));
                        checkOutput("retire_request", 32'(bus.imemRequest), 32'(!rr.halted));
                    end
                end
                prevValid = bus.instructionValid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.imemReady = 0; bus.imemData = 0; bus.execDone = 0; bus.stall = 0;
        bus.shouldUseNewPC = 0; bus.branchTo = 0; bus.halt = 0;
        bus2.imemReady = 0; bus2.imemData = 0; bus2.execDone = 0; bus2.stall = 0;
        bus2.shouldUseNewPC = 0; bus2.branchTo = 0; bus2.halt = 0;
        rst = 1'b0;
        tick();
        tick();
        checkOutput("reset_pc", bus.pcAddress, 32'd0);
        checkOutput("reset_instruction", bus.instruction, 32'd0);
        checkOutput("reset_valid", 32'(bus.instructionValid), 32'd0);
        checkOutput("reset_flush", 32'(bus.flush), 32'd0);
        checkOutput("reset_fault", 32'(bus.alignmentFault), 32'd0);
        checkOutput("reset_count", bus.retiredCount, 32'd0);
        checkOutput("reset_request", 32'(bus.imemRequest), 32'd0);
        rst = 1'b1;

        @(negedge clk);
        checkOutput("fetch_request", 32'(bus.imemRequest), 32'd1);
        checkOutput("fetch_address", bus.fetchAddress, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("midfetch_reset_request", 32'(bus.imemRequest), 32'd0);
        tick();
        rst = 1'b1;

        bus.imemReady = 1'b1;
        bus.imemData  = 32'h2001_0005;
        tick();
        bus.imemReady = 1'b0;
        checkOutput("first_instruction", bus.instruction, 32'h2001_0005);
        checkOutput("first_valid", 32'(bus.instructionValid), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("reset_exec_valid", 32'(bus.instructionValid), 32'd0);
        tick();
        rst = 1'b1;

        bus2.imemReady = 1'b1;
        bus2.imemData  = $urandom;
        tick();
        bus2.imemReady = 1'b0;
        bus2.execDone  = 1'b1;
        bus2.halt      = 1'b1;
        tick();
        bus2.execDone  = 1'b0;
        bus2.halt      = 1'b0;
        checkOutput("wrap_pc", bus2.pcAddress, 32'd0);
        checkOutput("wrap_count", bus2.retiredCount, 32'd1);
        checkOutput("wrap_halt_request", 32'(bus2.imemRequest), 32'd0);

        monitorOn = 1'b1;
        for (int n = 0; n < 150; n++) applyStimulus(n, n == 149);

        for (int i = 0; i < 6; i++) begin
            bus.imemReady = 1'($urandom % 2);
            bus.imemData  = $urandom;
            @(negedge clk);
            checkOutput("halt_request", 32'(bus.imemRequest), 32'd0);
            checkOutput("halt_valid", 32'(bus.instructionValid), 32'd0);
            checkOutput("halt_pc", bus.pcAddress, mPc);
            checkOutput("halt_count", bus.retiredCount, mCount);
        end
        checkOutput("queues_drained", 32'(issueQ.size() + retireQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
